// File: rtl/part_reg_chain.sv
// Elastic register chain of DEPTH WIDTH-bit stages with bubble collapse, clear/hold/output-enable
// controls and, in MODE 1, a transparent bypass that serves the consumer directly when empty.
module part_reg_chain #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int MODE  = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr_n,
    input  logic                       hold_n,
    input  logic                       oenb_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW        = $clog2(DEPTH + 1);
    localparam bit BYPASS_EN = (MODE == 1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [LW-1:0]    r_level;

    logic             w_hold_ok;
    logic             w_run;
    logic             w_out_en;
    logic             w_pop_en;
    logic             w_bypass;
    logic             w_bypass_xfer;
    logic             w_push;
    logic             w_pop_st;
    logic [DEPTH-1:0] w_adv;

    assign w_hold_ok = !reset && hold_n;
    assign w_run     = w_hold_ok && clr_n;
    assign w_out_en  = w_hold_ok && !oenb_n;
    assign w_pop_en  = w_run && !oenb_n && out_ready;
    assign w_bypass  = BYPASS_EN && w_run && !oenb_n && in_valid && !(|r_valid);

    // A stage advances if a bubble lies anywhere downstream, or everything downstream is full and the head pops.
    always_comb begin
        logic w_full_below;
        w_adv        = {DEPTH{1'b0}};
        w_full_below = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k]     = r_valid[k] && w_run && (!w_full_below || w_pop_en);
            w_full_below = w_full_below && r_valid[k];
        end
    end

    assign in_ready      = w_run && (!r_valid[0] || w_adv[0]);
    assign out_valid     = w_out_en && (r_valid[DEPTH-1] || w_bypass);
    assign w_bypass_xfer = w_bypass && out_ready;
    assign w_push        = in_valid && in_ready && !w_bypass_xfer;
    assign w_pop_st      = w_adv[DEPTH-1];
    assign level         = reset ? {LW{1'b0}} : r_level;

    // Head word select; forced to zero whenever nothing is presented.
    always_comb begin
        if (!out_valid) begin
            out_data = {WIDTH{1'b0}};
        end else if (w_bypass) begin
            out_data = in_data;
        end else begin
            out_data = r_data[DEPTH-1];
        end
    end

    // Stage registers and occupancy; reset and clear both wipe data as well as valid bits.
    always_ff @(posedge clock) begin
        if (reset || !clr_n) begin
            r_valid <= {DEPTH{1'b0}};
            r_level <= {LW{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= {WIDTH{1'b0}};
            end
        end else if (hold_n) begin
            if (w_push) begin
                r_valid[0] <= 1'b1;
                r_data[0]  <= in_data;
            end else if (w_adv[0]) begin
                r_valid[0] <= 1'b0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k-1]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= r_data[k-1];
                end else if (w_adv[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop_st);
        end
    end
endmodule

// File: tb/tb_part_reg_chain.sv
// Scoreboard bench: MODE 0 and MODE 1 instances, directed vectors, a forked monitor that
// queues accepted words and compares every word the consumer takes.
module tb_part_reg_chain;
    localparam int W  = 6;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);

    logic          clock = 1'b0;
    logic          reset, clr_n, hold_n, oenb_n, in_valid, in_valid1, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, in_ready1, out_valid1;
    logic [W-1:0]  out_data, out_data1;
    logic [LW-1:0] level, level1;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  q0[$];
    logic [W-1:0]  q1[$];

    always #5 clock = ~clock;

    part_reg_chain #(.WIDTH(W), .DEPTH(D), .MODE(0)) dut0 (
        .clock(clock), .reset(reset), .clr_n(clr_n), .hold_n(hold_n), .oenb_n(oenb_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .level(level)
    );

    part_reg_chain #(.WIDTH(W), .DEPTH(D), .MODE(1)) dut1 (
        .clock(clock), .reset(reset), .clr_n(clr_n), .hold_n(hold_n), .oenb_n(oenb_n),
        .in_valid(in_valid1), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .level(level1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        #2;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (in_valid && in_ready)   q0.push_back(in_data);
            if (in_valid1 && in_ready1) q1.push_back(in_data);
            if (out_valid && out_ready) begin
                if (q0.size() == 0) chk("mon0_extra", int'(out_valid), 0);
                else                chk("mon0_data", int'(out_data), int'(q0.pop_front()));
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("mon1_extra", int'(out_valid1), 0);
                else                chk("mon1_data", int'(out_data1), int'(q1.pop_front()));
            end
        end
    endtask

    initial begin
        reset = 1'b1; clr_n = 1'b1; hold_n = 1'b1; oenb_n = 1'b0;
        in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; in_data = 6'h00;
        fork
            monitor();
        join_none

        // Reset state
        cyc(); mid();
        chk("rst_level", int'(level), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_level1", int'(level1), 0);
        cyc(); reset = 1'b0;
        cyc(); mid();
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);

        // Latency of DEPTH cycles through an empty chain
        cyc(); out_ready = 1'b1; in_data = 6'h2A; in_valid = 1'b1; mid();
        chk("lat_in_ready", int'(in_ready), 1);
        for (int c = 1; c <= 5; c++) begin
            cyc(); in_valid = 1'b0; mid();
            chk($sformatf("lat_out_valid_c%0d", c), int'(out_valid), int'(c == 4));
            if (c == 4) chk("lat_out_data", int'(out_data), 32'h2A);
        end
        chk("lat_level", int'(level), 0);

        // Fill to full with the consumer stalled, then push and pop together
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc(); in_valid = 1'b1; in_data = W'(i); mid();
            chk($sformatf("fill_in_ready_%0d", i), int'(in_ready), int'(i <= 4));
        end
        chk("fill_level", int'(level), 4);
        cyc(); out_ready = 1'b1; mid();
        chk("full_pp_in_ready", int'(in_ready), 1);
        chk("full_pp_head", int'(out_data), 1);
        cyc(); in_valid = 1'b0; mid();
        chk("full_pp_level", int'(level), 4);
        for (int n = 0; n < 20 && q0.size() != 0; n++) cyc();
        chk("drain0_empty", q0.size(), 0);
        mid();
        chk("drain0_level", int'(level), 0);

        // Clear with level 3 and a word offered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); in_valid = 1'b1; in_data = 6'h30 + W'(i); mid();
        end
        cyc(); in_data = 6'h3F; clr_n = 1'b0; mid();
        chk("clr_level_before", int'(level), 3);
        chk("clr_in_ready", int'(in_ready), 0);
        cyc(); clr_n = 1'b1; in_valid = 1'b0; q0.delete(); mid();
        chk("clr_level", int'(level), 0);
        chk("clr_out_valid", int'(out_valid), 0);
        chk("clr_out_data", int'(out_data), 0);

        // Output disable: head stays put, output reads zero
        cyc(); in_valid = 1'b1; in_data = 6'h11; mid();
        for (int i = 0; i < 4; i++) begin
            cyc(); in_valid = 1'b0; mid();
        end
        chk("oe_head_valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); oenb_n = 1'b1; out_ready = 1'b1; mid();
            chk($sformatf("oe_off_valid_%0d", i), int'(out_valid), 0);
            chk($sformatf("oe_off_data_%0d", i), int'(out_data), 0);
            chk($sformatf("oe_off_level_%0d", i), int'(level), 1);
        end
        cyc(); oenb_n = 1'b0; mid();
        chk("oe_on_valid", int'(out_valid), 1);
        chk("oe_on_data", int'(out_data), 32'h11);
        cyc(); out_ready = 1'b0; mid();
        chk("oe_after_level", int'(level), 0);

        // Hold freezes everything, then a reset pulse mid-stream
        for (int i = 0; i < 2; i++) begin
            cyc(); in_valid = 1'b1; in_data = 6'h21 + W'(i); mid();
        end
        cyc(); in_data = 6'h23; hold_n = 1'b0; out_ready = 1'b1; mid();
        chk("hold_level", int'(level), 2);
        chk("hold_in_ready", int'(in_ready), 0);
        chk("hold_out_valid", int'(out_valid), 0);
        cyc(); mid();
        chk("hold_level_kept", int'(level), 2);
        cyc(); hold_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1; mid();
        chk("rstmid_level", int'(level), 0);
        chk("rstmid_in_ready", int'(in_ready), 0);
        cyc(); reset = 1'b0; q0.delete(); out_ready = 1'b1; mid();
        chk("rstmid_level_after", int'(level), 0);
        chk("rstmid_out_valid", int'(out_valid), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(); mid();
            chk($sformatf("rstmid_no_out_%0d", i), int'(out_valid), 0);
        end

        // MODE 1 bypass with and without a ready consumer
        cyc(); in_valid1 = 1'b1; in_data = 6'h15; out_ready = 1'b1; mid();
        chk("byp_out_valid", int'(out_valid1), 1);
        chk("byp_out_data", int'(out_data1), 32'h15);
        chk("byp_in_ready", int'(in_ready1), 1);
        cyc(); in_valid1 = 1'b0; mid();
        chk("byp_level", int'(level1), 0);
        chk("byp_after_valid", int'(out_valid1), 0);
        cyc(); in_valid1 = 1'b1; in_data = 6'h16; out_ready = 1'b0; mid();
        chk("byp2_out_valid", int'(out_valid1), 1);
        chk("byp2_out_data", int'(out_data1), 32'h16);
        cyc(); in_valid1 = 1'b0; mid();
        chk("byp2_level", int'(level1), 1);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q1.size() != 0; n++) cyc();
        chk("drain1_empty", q1.size(), 0);
        mid();
        chk("drain1_level", int'(level1), 0);
        chk("final_q0_empty", q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
